inv_mixcolumns_iter: RTL
========================

# inv_mixcolumns_iter

Iterative AES InvMixColumns stage for the decryption datapath: the inverse of the encryption MixColumns stage. It accepts a 128-bit column-major state over a valid/ready handshake and applies the InvMixColumns matrix [0e 0b 0d 09 / 09 0e 0b 0d / 0d 09 0e 0b / 0b 0d 09 0e] over GF(2^8). Processing is COLS_PER_CYCLE columns per clock. The result is held until the downstream stage accepts it. The block sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

## Interface
- NB, 4, columns/rows of state; fixed at 4.
- WORD, 8, bits per byte; fixed at 8.
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  input block valid.
- i_ready  output  1  block can accept input this cycle.
- i_block  input  128  input state, column-major; column c occupies bits [127-32c -: 32], row 0 in the MSB byte.
- o_valid  output  1  o_block holds a finished result.
- o_ready  input  1  downstream accepts o_block this cycle.
- o_block  output  128  transformed state, same byte ordering as i_block.

## Operation
- Byte math: xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0), truncated to 8 bits.
  - x2 = xtime(a), x4 = xtime(x2), x8 = xtime(x4).
  - 09 = x8^a; 0b = x8^x2^a; 0d = x8^x4^a; 0e = x8^x4^x2.
- Column output r = M·a:
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3.
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3.
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3.
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3.
- Registers:
  - state_q (128), working state, doubles as o_block.
  - col_q, log2(NB) bits, index of the next column to process.
  - fsm_q, encoded IDLE/BUSY/DONE.
- FSM:
  - IDLE: i_ready=1, o_valid=0. On i_valid: state_q<=i_block, col_q<=0, go BUSY.
  - BUSY: i_ready=0, o_valid=0. Each clock, columns col_q..col_q+COLS_PER_CYCLE-1 of state_q are replaced by their transformed values, and col_q += COLS_PER_CYCLE.
    - When the last column is written (col_q+COLS_PER_CYCLE == NB), col_q wraps to 0 and the FSM goes to DONE.
  - DONE: o_valid=1, and o_block is stable while o_valid && !o_ready.
    - On o_ready && !i_valid: go IDLE.
    - On o_ready && i_valid: load the new block and go BUSY (back-to-back).
- i_ready = (fsm_q==IDLE) || (fsm_q==DONE && o_ready). This is combinational from o_ready; no other combinational input-to-output path is allowed.
- i_valid while i_ready=0 is ignored; the upstream must hold the block.
- i_block is sampled only on the accepting edge. Changes on i_block during BUSY have no effect.

## Timing
- Reset (asynchronous):
  - fsm_q=IDLE, col_q=0, state_q=0.
  - Outputs: o_valid=0, o_block=0, i_ready=1.
- Reset asserted mid-BUSY or mid-DONE aborts the block. No output is produced; on release the block is in IDLE.
- Latency: with the accept at edge E, o_valid rises after edge E+NB/COLS_PER_CYCLE (4, 2 or 1 cycles).
- Throughput with o_ready held high: one block per NB/COLS_PER_CYCLE+1 cycles, with no idle cycle between a consume and the next accept.
- o_valid falls on the edge after the o_ready handshake, unless that same edge accepted a new block. In that case o_valid is 0 during BUSY and rises again after the latency above.

## Structure
- Shared package aes_pkg:
  - NB/WORD constants.
  - xtime, gf_mul9/b/d/e functions (also reused by the key schedule and the forward MixColumns).
  - FSM state enum, typedef state_t (128-bit), col_t (32-bit).
- One combinational sub-module, inv_mixcolumn_col:
  - 32-bit column in, 32-bit column out.
  - Instantiated COLS_PER_CYCLE times with a generate loop.
  - Column selection uses a mux on col_q.
- Remainder (FSM, counter, state register, handshake) lives in inv_mixcolumns_iter.

## Test plan
- Column vectors, COLS_PER_CYCLE=1: i_block=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> o_block=db135345_f20a225c_01010101_d4d4d4d5, o_valid rising 4 cycles after accept.
- Round-trip: 1000 random blocks through the forward MixColumns then this block -> output equals original. Run for each COLS_PER_CYCLE; latencies 4/2/1.
- Backpressure: hold o_ready=0 for 10 cycles after o_valid -> o_block stable, o_valid=1, i_ready=0, a new i_valid ignored. Raise o_ready with i_valid=1 -> new block accepted on the same edge.
- Streaming, o_ready=1, i_valid=1 continuously with COLS_PER_CYCLE=1 -> accepts every 5 cycles, results in order. i_block=c6c6c6c6 repeated -> o_block=c6c6c6c6 repeated.
- Reset mid-BUSY (col_q=2): assert rst -> o_valid=0, o_block=0, i_ready=1 immediately. The next block 2d26314c×4 is processed correctly: output 4d7ebdf8→2d26314c check using the inverse pair, i_block=4d7ebdf8×4 -> o_block=2d26314c×4.
- Input ignore: toggle i_block randomly during BUSY -> result matches the block sampled at accept.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, types and GF(2^8) helpers used by the
//               InvMixColumns stage, the forward MixColumns and the key
//               schedule.
//               c_nb / c_word   : state dimension and byte width
//               state_t / col_t : 128-bit state, 32-bit column
//               fsm_t           : iterative-stage controller states
//               xtime, gf_mul9/b/d/e : constant multipliers in GF(2^8)
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int c_nb   = 4;
    localparam int c_word = 8;

    typedef logic [c_nb*c_nb*c_word-1:0] state_t;
    typedef logic [c_nb*c_word-1:0]      col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(a)));
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] a);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mixcolumn_col.sv
`default_nettype none
// ============================================================================
// Module      : inv_mixcolumn_col
// Description : Combinational InvMixColumns of a single 32-bit column.
//               i_col : input column, row 0 in bits [31:24]
//               o_col : transformed column, same byte ordering
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mixcolumn_col
    import aes_pkg::*;
(
    input  col_t i_col,
    output col_t o_col
);

    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    // Circulant matrix rows [0e 0b 0d 09] rotated right by the row index.
    assign o_col[31:24] = gf_mule(w_a0) ^ gf_mulb(w_a1) ^ gf_muld(w_a2) ^ gf_mul9(w_a3);
    assign o_col[23:16] = gf_mul9(w_a0) ^ gf_mule(w_a1) ^ gf_mulb(w_a2) ^ gf_muld(w_a3);
    assign o_col[15:8]  = gf_muld(w_a0) ^ gf_mul9(w_a1) ^ gf_mule(w_a2) ^ gf_mulb(w_a3);
    assign o_col[7:0]   = gf_mulb(w_a0) ^ gf_muld(w_a1) ^ gf_mul9(w_a2) ^ gf_mule(w_a3);

endmodule
`default_nettype wire

// File: rtl/inv_mixcolumns_iter.sv
`default_nettype none
// ============================================================================
// Module      : inv_mixcolumns_iter
// Description : Iterative AES InvMixColumns stage, COLS_PER_CYCLE columns per
//               clock, valid/ready on both sides, result held until consumed.
//               clk, rst          : clock (rising), async active-high reset
//               i_valid/i_ready   : input handshake, i_block 128-bit state
//               o_valid/o_ready   : output handshake, o_block 128-bit state
//               Column c occupies bits [127-32c -: 32], row 0 in the MSB byte.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mixcolumns_iter
    import aes_pkg::*;
#(
    parameter int NB             = 4,
    parameter int WORD           = 8,
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [NB*NB*WORD-1:0]    i_block,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [NB*NB*WORD-1:0]    o_block
);

    localparam int c_col_w    = NB * WORD;
    localparam int c_blk_w    = NB * c_col_w;
    localparam int c_col_bits = $clog2(NB);

    // Column increment; for COLS_PER_CYCLE == NB this truncates to zero,
    // which is harmless because every step is then the last one.
    localparam logic [c_col_bits-1:0] c_col_inc = c_col_bits'(COLS_PER_CYCLE);

    fsm_t                  r_fsm;
    logic [c_col_bits-1:0] r_col;
    logic [c_blk_w-1:0]    r_state;

    fsm_t                  w_fsm_nxt;
    logic [c_col_bits-1:0] w_col_nxt;
    logic [c_blk_w-1:0]    w_state_nxt;
    logic [c_blk_w-1:0]    w_state_proc;
    logic                  w_accept;
    logic                  w_last;

    logic [c_col_w-1:0]    w_col_in  [COLS_PER_CYCLE];
    logic [c_col_w-1:0]    w_col_out [COLS_PER_CYCLE];

    // ------------------------------------------------------------------
    // Column select: lane k works on column r_col + k. r_col is always a
    // multiple of COLS_PER_CYCLE, so lanes never run past the last column.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_col_in[k] = '0;
            for (int c = 0; c < NB; c++) begin
                if (int'(r_col) + k == c) begin
                    w_col_in[k] = r_state[(NB-1-c)*c_col_w +: c_col_w];
                end
            end
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_cols
        inv_mixcolumn_col u_col (
            .i_col (w_col_in[g]),
            .o_col (w_col_out[g])
        );
    end

    // Merge transformed lanes back into the working state.
    always_comb begin
        w_state_proc = r_state;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (int'(r_col) + k == c) begin
                    w_state_proc[(NB-1-c)*c_col_w +: c_col_w] = w_col_out[k];
                end
            end
        end
    end

    assign w_last   = (int'(r_col) + COLS_PER_CYCLE == NB);

    // ------------------------------------------------------------------
    // Handshake: i_ready looks through o_ready in DONE so a consume and the
    // next accept can share one edge.
    // ------------------------------------------------------------------
    assign i_ready  = (r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && o_ready);
    assign w_accept = i_valid && i_ready;
    assign o_valid  = (r_fsm == ST_DONE);
    assign o_block  = r_state;

    // ------------------------------------------------------------------
    // Controller: next-state / datapath selection
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_col_nxt   = r_col;
        w_state_nxt = r_state;
        case (r_fsm)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = i_block;
                    w_col_nxt   = '0;
                    w_fsm_nxt   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_state_nxt = w_state_proc;
                if (w_last) begin
                    w_col_nxt = '0;
                    w_fsm_nxt = ST_DONE;
                end else begin
                    w_col_nxt = r_col + c_col_inc;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = i_block;
                    w_col_nxt   = '0;
                    w_fsm_nxt   = ST_BUSY;
                end else if (o_ready) begin
                    w_fsm_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
                w_col_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_col   <= '0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_col   <= w_col_nxt;
            r_state <= w_state_nxt;
        end
    end

endmodule
`default_nettype wire
